// File: rtl/weight_read_sequencer.sv
// weight_read_sequencer: streams activations against a neuron's weight memory
// and presents latency-aligned (x, w) pairs with first/last tags to the MAC.
module weight_read_sequencer #(
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int numWeight    = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  x_valid,
    input  logic [dataWidth-1:0]  x_data,
    output logic                  x_ready,
    output logic                  w_ren,
    output logic [addressWidth:0] w_raddr,
    input  logic [dataWidth-1:0]  w_data,
    output logic                  mac_valid,
    output logic [dataWidth-1:0]  mac_x,
    output logic [dataWidth-1:0]  mac_w,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = addressWidth + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(numWeight - 1);

    if (numWeight < 1 || numWeight > (1 << addressWidth)) begin : g_bad_num
        $error("weight_read_sequencer: numWeight out of range");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic                   s1_valid_q;
    logic                   s1_first_q;
    logic                   s1_last_q;
    logic [dataWidth-1:0]   s1_x_q;
    logic                   mac_valid_q;
    logic [dataWidth-1:0]   mac_x_q;
    logic [dataWidth-1:0]   mac_w_q;
    logic                   mac_first_q;
    logic                   mac_last_q;
    logic                   fire;
    logic                   is_last;

    assign x_ready   = (state_q == RUN);
    assign fire      = x_valid & x_ready;
    assign w_ren     = fire;
    assign w_raddr   = idx_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign is_last   = (idx_q == LAST_IDX);
    assign mac_valid = mac_valid_q;
    assign mac_x     = mac_x_q;
    assign mac_w     = mac_w_q;
    assign mac_first = mac_first_q;
    assign mac_last  = mac_last_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (fire) begin
                    idx_d = idx_q + 1'b1;
                    if (is_last) state_d = DRAIN;
                end
            end
            // Wait for the final pair to leave stage 1 before signalling done
            DRAIN: begin
                if (!s1_valid_q) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Stage 1 holds x while the weight read is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_x_q     <= '0;
        end else if (abort) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= fire;
            if (fire) begin
                s1_x_q     <= x_data;
                s1_first_q <= (idx_q == '0);
                s1_last_q  <= is_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_valid_q <= 1'b0;
            mac_x_q     <= '0;
            mac_w_q     <= '0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
        end else if (abort) begin
            mac_valid_q <= 1'b0;
        end else begin
            mac_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mac_x_q     <= s1_x_q;
                mac_w_q     <= w_data;
                mac_first_q <= s1_first_q;
                mac_last_q  <= s1_last_q;
            end
        end
    end

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Scoreboard bench for weight_read_sequencer: a 4-weight instance for the
// streaming/abort/reset cases and a 1-weight instance for the degenerate pass.
module tb_weight_read_sequencer;

    localparam int DW  = 16;
    localparam int AWA = 4;
    localparam int NWA = 4;
    localparam int AWB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, start, abort, x_valid;
    logic [DW-1:0]  x_data, w_data;
    logic           x_ready, w_ren, mac_valid, mac_first, mac_last, busy, done;
    logic [AWA:0]   w_raddr;
    logic [DW-1:0]  mac_x, mac_w;

    logic           b_start, b_abort, b_x_valid;
    logic [DW-1:0]  b_x_data, b_w_data;
    logic           b_x_ready, b_w_ren, b_mac_valid, b_mac_first, b_mac_last;
    logic           b_busy, b_done;
    logic [AWB:0]   b_w_raddr;
    logic [DW-1:0]  b_mac_x, b_mac_w;

    weight_read_sequencer #(.addressWidth(AWA), .dataWidth(DW), .numWeight(NWA)) u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
        .w_ren(w_ren), .w_raddr(w_raddr), .w_data(w_data),
        .mac_valid(mac_valid), .mac_x(mac_x), .mac_w(mac_w),
        .mac_first(mac_first), .mac_last(mac_last), .busy(busy), .done(done)
    );

    weight_read_sequencer #(.addressWidth(AWB), .dataWidth(DW), .numWeight(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
        .x_valid(b_x_valid), .x_data(b_x_data), .x_ready(b_x_ready),
        .w_ren(b_w_ren), .w_raddr(b_w_raddr), .w_data(b_w_data),
        .mac_valid(b_mac_valid), .mac_x(b_mac_x), .mac_w(b_mac_w),
        .mac_first(b_mac_first), .mac_last(b_mac_last), .busy(b_busy), .done(b_done)
    );

    function automatic logic [DW-1:0] memv(input int a);
        return DW'(32'h5A00 ^ (a * 37));
    endfunction

    always @(posedge clk) if (w_ren) w_data <= memv(int'(w_raddr));
    always @(posedge clk) if (b_w_ren) b_w_data <= memv(int'(b_w_raddr));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] w;
        logic          f;
        logic          l;
        int            fc;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic exp_run = 1'b0;
    int   exp_idx = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   last_cyc = -100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
    endtask

    // Issue side: each expected fire pushes its expected pair
    exp_t ie;
    always @(negedge clk) begin
        if (!rst) begin
            if (!exp_run) exp_idx = 0;
            chk("x_ready", x_ready, exp_run);
            chk("w_ren", w_ren, x_valid & exp_run);
            if (x_valid && exp_run) begin
                chk("w_raddr", w_raddr, exp_idx);
                ie.x  = x_data;
                ie.w  = memv(exp_idx);
                ie.f  = (exp_idx == 0);
                ie.l  = (exp_idx == NWA - 1);
                ie.fc = cyc;
                q.push_back(ie);
                exp_idx++;
            end
        end
    end

    exp_t me;
    always @(negedge clk) begin
        if (mac_valid) begin
            if (q.size() == 0) begin
                chk("mac_unexpected", 1, 0);
            end else begin
                me = q.pop_front();
                chk("mac_x", mac_x, me.x);
                chk("mac_w", mac_w, me.w);
                chk("mac_first", mac_first, me.f);
                chk("mac_last", mac_last, me.l);
                chk("mac_latency", cyc, me.fc + 2);
                if (me.l) last_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_last", cyc, last_cyc + 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int s);
        start = 1'b1;
        s = cyc;
        step();
        start = 1'b0;
        exp_run = 1'b1;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_count", done_cnt, d0 + 1);
    endtask

    task automatic purge(input int kf);
        while (q.size() > 0 && q[$].fc >= kf) void'(q.pop_back());
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_mac_valid"}, mac_valid, 0);
        chk({t, "_x_ready"}, x_ready, 0);
        chk({t, "_w_ren"}, w_ren, 0);
        chk({t, "_w_raddr"}, w_raddr, 0);
        chk({t, "_mac_x"}, mac_x, 0);
        chk({t, "_mac_w"}, mac_w, 0);
        chk({t, "_mac_first"}, mac_first, 0);
        chk({t, "_mac_last"}, mac_last, 0);
        chk({t, "_busy"}, busy, 0);
        chk({t, "_done"}, done, 0);
    endtask

    task automatic fires(input logic [DW-1:0] base);
        for (int k = 0; k < NWA; k++) begin
            x_valid = 1'b1;
            x_data  = base + DW'(k);
            step();
        end
        x_valid = 1'b0;
        exp_run = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s;
        int d0;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        rst = 1'b1; start = 1'b0; abort = 1'b0; x_valid = 1'b0; x_data = '0;
        b_start = 1'b0; b_abort = 1'b0; b_x_valid = 1'b0; b_x_data = '0;
        @(negedge clk);
        chk_zero("reset");
        chk("reset_b_busy", b_busy, 0);
        chk("reset_b_mac_valid", b_mac_valid, 0);
        step();
        rst = 1'b0;
        step();

        // T1: continuous stream
        d0 = done_cnt;
        do_start(s);
        fires(16'h1000);
        wait_done(d0);
        chk("t1_done_cycle", done_cyc, s + 7);
        chk("t1_busy_in_done", busy, 1);
        @(negedge clk);
        chk("t1_busy_after", busy, 0);
        step();

        // T2: gapped stream
        d0 = done_cnt;
        do_start(s);
        for (int j = 0; j < 7; j++) begin
            x_valid = pat[j][0];
            x_data  = 16'h2000 + DW'(j);
            step();
        end
        x_valid = 1'b0;
        exp_run = 1'b0;
        wait_done(d0);
        chk("t2_done_cycle", done_cyc, s + 10);
        step();

        // T3: start during RUN ignored
        d0 = done_cnt;
        do_start(s);
        for (int k = 0; k < NWA; k++) begin
            x_valid = 1'b1;
            start   = (k == 2);
            x_data  = 16'h3000 + DW'(k);
            step();
        end
        x_valid = 1'b0; start = 1'b0; exp_run = 1'b0;
        wait_done(d0);
        repeat (6) @(negedge clk);
        chk("t3_single_done", done_cnt, d0 + 1);
        chk("t3_idle", busy, 0);
        step();

        // T4: abort after index 1, then start+abort in IDLE, then restart
        d0 = done_cnt;
        do_start(s);
        x_valid = 1'b1; x_data = 16'h4000;
        step();
        x_data = 16'h4001;
        step();
        x_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0; exp_run = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_mac_valid", mac_valid, 0);
        chk("t4_busy", busy, 0);
        purge(s + 2);
        repeat (4) @(negedge clk);
        chk("t4_no_done", done_cnt, d0);
        step();
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("t4_abort_wins", busy, 0);
        step();
        d0 = done_cnt;
        do_start(s);
        fires(16'h4100);
        wait_done(d0);
        step();

        // T5: reset mid-DRAIN
        d0 = done_cnt;
        do_start(s);
        fires(16'h5000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("t5");
        purge(s + 4);
        repeat (5) @(negedge clk);
        chk("t5_no_done", done_cnt, d0);
        step();
        do_start(s);
        fires(16'h5100);
        wait_done(d0);
        step();

        // T6: single-weight pass
        b_start = 1'b1;
        step();
        b_start = 1'b0; b_x_valid = 1'b1; b_x_data = 16'hBEEF;
        @(negedge clk);
        chk("t6_x_ready", b_x_ready, 1);
        chk("t6_w_ren", b_w_ren, 1);
        chk("t6_w_raddr", b_w_raddr, 0);
        step();
        b_x_valid = 1'b0;
        @(negedge clk);
        chk("t6_x_ready_off", b_x_ready, 0);
        chk("t6_gap", b_mac_valid, 0);
        step();
        @(negedge clk);
        chk("t6_mac_valid", b_mac_valid, 1);
        chk("t6_mac_first", b_mac_first, 1);
        chk("t6_mac_last", b_mac_last, 1);
        chk("t6_mac_x", b_mac_x, 16'hBEEF);
        chk("t6_mac_w", b_mac_w, memv(0));
        chk("t6_done_early", b_done, 0);
        step();
        @(negedge clk);
        chk("t6_done", b_done, 1);
        chk("t6_mac_valid_off", b_mac_valid, 0);
        step();
        @(negedge clk);
        chk("t6_done_pulse", b_done, 0);
        chk("t6_idle", b_busy, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
